// File: rtl/aud_freq_divider_pkg.sv
// Shared constants and reload helper for the audio channel-pair frequency divider.
package aud_freq_divider_pkg;

    localparam int unsigned AUDF_W         = 8;
    localparam int unsigned CNT_W          = AUDF_W + 1;
    localparam int unsigned JOIN_W         = 2 * AUDF_W + 1;
    localparam int unsigned FAST_OFS8_DEF  = 3;
    localparam int unsigned FAST_OFS16_DEF = 6;

    // The extra bit above AUDF holds the fast-clock offset without wrapping.
    function automatic logic [CNT_W-1:0] reload8(
        input logic [AUDF_W-1:0] audf,
        input logic              fast,
        input int unsigned       ofs
    );
        return {1'b0, audf} + (fast ? CNT_W'(ofs) : {CNT_W{1'b0}});
    endfunction

endpackage

// File: rtl/aud_down_counter.sv
// Loadable down counter with zero flag; one instance per audio channel.
module aud_down_counter
    import aud_freq_divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(negedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/aud_freq_divider.sv
// Audio channel-pair divider: two 8-bit dividers or one joined 16-bit divider,
// producing one-enn-wide tick pulses for the poly-counter stage.
module aud_freq_divider
    import aud_freq_divider_pkg::*;
#(
    parameter int unsigned FAST_OFS8  = FAST_OFS8_DEF,
    parameter int unsigned FAST_OFS16 = FAST_OFS16_DEF
) (
    input  logic              clk,
    input  logic              init,
    input  logic              enn,
    input  logic              audClock,
    input  logic              fast_lo,
    input  logic              fast_hi,
    input  logic              join_en,
    input  logic [AUDF_W-1:0] audf_lo,
    input  logic [AUDF_W-1:0] audf_hi,
    input  logic              stimer,
    output logic              tick_lo,
    output logic              tick_hi
);

    logic              join_q;
    logic              ce_lo, ce_hi, force_ld;
    logic              zero_lo, zero_hi;
    logic              en_lo, en_hi, ld_lo, ld_hi;
    logic [CNT_W-1:0]  val_lo, val_hi;
    logic [CNT_W-1:0]  rl_lo, rl_hi, jrl_lo, jrl_hi;
    logic [JOIN_W-1:0] join_sum;
    logic              tick_lo_nxt, tick_hi_nxt;

    assign ce_lo    = enn & (fast_lo | audClock);
    assign ce_hi    = enn & (fast_hi | audClock);
    assign force_ld = enn & (stimer | (join_en != join_q));

    assign rl_lo = reload8(audf_lo, fast_lo, FAST_OFS8);
    assign rl_hi = reload8(audf_hi, fast_hi, FAST_OFS8);

    // Joined reload: the fast offset may carry out of the low byte into hi.
    assign join_sum = {1'b0, audf_hi, audf_lo}
                    + (fast_lo ? JOIN_W'(FAST_OFS16) : {JOIN_W{1'b0}});
    assign jrl_lo   = {1'b0, join_sum[AUDF_W-1:0]};
    assign jrl_hi   = join_sum[JOIN_W-1:AUDF_W];

    always_comb begin
        en_lo       = 1'b0;
        en_hi       = 1'b0;
        ld_lo       = 1'b0;
        ld_hi       = 1'b0;
        val_lo      = rl_lo;
        val_hi      = rl_hi;
        tick_lo_nxt = 1'b0;
        tick_hi_nxt = 1'b0;
        if (force_ld) begin
            ld_lo = 1'b1;
            ld_hi = 1'b1;
            if (join_en) begin
                val_lo = jrl_lo;
                val_hi = jrl_hi;
            end
        end else if (join_en) begin
            if (ce_lo) begin
                if (!zero_lo) begin
                    en_lo = 1'b1;
                end else if (zero_hi) begin
                    ld_lo       = 1'b1;
                    ld_hi       = 1'b1;
                    val_lo      = jrl_lo;
                    val_hi      = jrl_hi;
                    tick_hi_nxt = 1'b1;
                end else begin
                    // Borrow from the upper byte and restart the low byte.
                    ld_lo  = 1'b1;
                    val_lo = {1'b0, {AUDF_W{1'b1}}};
                    en_hi  = 1'b1;
                end
            end
        end else begin
            if (ce_lo) begin
                ld_lo       = zero_lo;
                en_lo       = !zero_lo;
                tick_lo_nxt = zero_lo;
            end
            if (ce_hi) begin
                ld_hi       = zero_hi;
                en_hi       = !zero_hi;
                tick_hi_nxt = zero_hi;
            end
        end
    end

    aud_down_counter u_cnt_lo (
        .clk      (clk),
        .rst      (init),
        .en       (en_lo),
        .load     (ld_lo),
        .load_val (val_lo),
        .zero     (zero_lo)
    );

    aud_down_counter u_cnt_hi (
        .clk      (clk),
        .rst      (init),
        .en       (en_hi),
        .load     (ld_hi),
        .load_val (val_hi),
        .zero     (zero_hi)
    );

    always_ff @(negedge clk) begin
        if (init) begin
            tick_lo <= 1'b0;
            tick_hi <= 1'b0;
            join_q  <= join_en;
        end else if (enn) begin
            tick_lo <= tick_lo_nxt;
            tick_hi <= tick_hi_nxt;
            join_q  <= join_en;
        end
    end

endmodule

// File: tb/tb_aud_freq_divider.sv
// Scoreboard bench for aud_freq_divider: expected tick times (in enn edges) are
// queued by the stimulus and matched by a monitor whenever a tick appears.
module tb_aud_freq_divider;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic       enn = 1'b0;
    logic       audClock = 1'b0;
    logic       fast_lo = 1'b0;
    logic       fast_hi = 1'b0;
    logic       join_en = 1'b0;
    logic [7:0] audf_lo = 8'd0;
    logic [7:0] audf_hi = 8'd0;
    logic       stimer = 1'b0;
    logic       tick_lo, tick_hi;

    int checks = 0;
    int failures = 0;
    int ecount = 0;
    logic enn_edge = 1'b0;
    int q_lo[$];
    int q_hi[$];
    int e0;

    aud_freq_divider dut (
        .clk      (clk),
        .init     (init),
        .enn      (enn),
        .audClock (audClock),
        .fast_lo  (fast_lo),
        .fast_hi  (fast_hi),
        .join_en  (join_en),
        .audf_lo  (audf_lo),
        .audf_hi  (audf_hi),
        .stimer   (stimer),
        .tick_lo  (tick_lo),
        .tick_hi  (tick_hi)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        enn_edge <= enn;
        if (enn) ecount <= ecount + 1;
    end

    // Monitor: every tick seen after an enn edge must match the queue head.
    always @(posedge clk) begin
        if (enn_edge) begin
            if (tick_lo) begin
                checks++;
                if (q_lo.size() == 0) begin
                    failures++;
                    $display("FAIL tick_lo_extra: tick at enn %0d, none expected", ecount);
                end else begin
                    int exp_t;
                    exp_t = q_lo.pop_front();
                    if (exp_t != ecount) begin
                        failures++;
                        $display("FAIL tick_lo_time: tick at enn %0d, expected enn %0d", ecount, exp_t);
                    end
                end
            end
            if (tick_hi) begin
                checks++;
                if (q_hi.size() == 0) begin
                    failures++;
                    $display("FAIL tick_hi_extra: tick at enn %0d, none expected", ecount);
                end else begin
                    int exp_t;
                    exp_t = q_hi.pop_front();
                    if (exp_t != ecount) begin
                        failures++;
                        $display("FAIL tick_hi_time: tick at enn %0d, expected enn %0d", ecount, exp_t);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick(input logic ac, input logic st);
        @(posedge clk);
        enn = 1'b1;
        audClock = ac;
        stimer = st;
        @(posedge clk);
        enn = 1'b0;
        audClock = 1'b0;
        stimer = 1'b0;
    endtask

    task automatic do_reset(input logic j);
        @(posedge clk);
        init = 1'b1;
        join_en = j;
        enn = 1'b1;
        @(posedge clk);
        enn = 1'b0;
        @(posedge clk);
        init = 1'b0;
        e0 = ecount;
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        chk({name, "_lo_pending"}, q_lo.size(), 0);
        chk({name, "_hi_pending"}, q_hi.size(), 0);
        q_lo.delete();
        q_hi.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: slow clocking, audClock every 28 enn; lo period 5 pulses, hi 10.
        audf_lo = 8'd4;
        audf_hi = 8'd9;
        do_reset(1'b0);
        @(negedge clk);
        chk("reset_tick_lo", int'(tick_lo), 0);
        chk("reset_tick_hi", int'(tick_hi), 0);
        q_lo.push_back(e0 + 1);
        q_lo.push_back(e0 + 141);
        q_lo.push_back(e0 + 281);
        q_hi.push_back(e0 + 1);
        q_hi.push_back(e0 + 281);
        for (int k = 1; k <= 300; k++) tick(((k - 1) % 28) == 0, 1'b0);
        drain("t1");

        // Test 2: fast lo, audf 0 (period 4), then 255 mid-count (period 259).
        fast_lo = 1'b1;
        audf_lo = 8'd0;
        audf_hi = 8'd0;
        do_reset(1'b0);
        q_lo.push_back(e0 + 1);
        q_lo.push_back(e0 + 5);
        q_lo.push_back(e0 + 9);
        q_lo.push_back(e0 + 13);
        q_lo.push_back(e0 + 272);
        q_lo.push_back(e0 + 531);
        for (int k = 1; k <= 540; k++) begin
            if (k == 13) audf_lo = 8'd255;
            tick(1'b0, 1'b0);
        end
        drain("t2");

        // Test 3: joined, fast, N=0x0100 -> period 263; tick_lo silent.
        audf_hi = 8'h01;
        audf_lo = 8'h00;
        do_reset(1'b1);
        q_hi.push_back(e0 + 1);
        q_hi.push_back(e0 + 264);
        q_hi.push_back(e0 + 527);
        for (int k = 1; k <= 530; k++) tick(1'b0, 1'b0);
        drain("t3");

        // Test 4: stimer at edge 20, join on at 50 (period 16), off at 90.
        audf_hi = 8'd0;
        audf_lo = 8'd9;
        do_reset(1'b0);
        q_lo.push_back(e0 + 1);
        q_lo.push_back(e0 + 14);
        q_lo.push_back(e0 + 33);
        q_lo.push_back(e0 + 46);
        q_lo.push_back(e0 + 103);
        q_hi.push_back(e0 + 66);
        q_hi.push_back(e0 + 82);
        for (int k = 1; k <= 110; k++) begin
            if (k == 50) join_en = 1'b1;
            if (k == 90) join_en = 1'b0;
            tick(1'b0, k == 20);
        end
        drain("t4");

        // Test 5: fast hi, audf_hi 10 -> 2 mid-count: 14-enn period then 6.
        fast_lo = 1'b0;
        fast_hi = 1'b1;
        audf_hi = 8'd10;
        audf_lo = 8'd0;
        do_reset(1'b0);
        q_hi.push_back(e0 + 1);
        q_hi.push_back(e0 + 15);
        q_hi.push_back(e0 + 29);
        q_hi.push_back(e0 + 35);
        q_hi.push_back(e0 + 41);
        for (int k = 1; k <= 45; k++) begin
            if (k == 21) audf_hi = 8'd2;
            tick(1'b0, 1'b0);
        end
        drain("t5");

        // Test 6: init with enn=0 while tick_lo is high and lo mid-count.
        fast_hi = 1'b0;
        audf_hi = 8'd0;
        fast_lo = 1'b1;
        audf_lo = 8'd9;
        do_reset(1'b0);
        q_lo.push_back(e0 + 1);
        tick(1'b0, 1'b0);
        init = 1'b1;
        @(negedge clk);
        #1;
        chk("init_noenn_tick_lo", int'(tick_lo), 0);
        chk("init_noenn_tick_hi", int'(tick_hi), 0);
        @(posedge clk);
        init = 1'b0;
        e0 = ecount;
        q_lo.push_back(e0 + 1);
        q_lo.push_back(e0 + 14);
        for (int k = 1; k <= 20; k++) tick(1'b0, 1'b0);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
